usb_spi_master: RTL
===================

// Module: usb_spi_master
// PURPOSE
//  Avalon-MM slave SPI master that sequences byte transfers to the USB host controller chip.
//  It drives SCK/SDI/CS_n and samples the chip's SDO line, replacing software bit-banging through PIO ports.
//  Sits on the SOPC system bus beside the other peripherals; one CPU write starts one 8-bit full-duplex transfer.
// PARAMETERS
//  DIV_RESET  8'd4  reset value of the clock divider; SCK half-period = (div+1) clk cycles
//  DATA_W     8     bits per transfer, MSB first
// PORTS
//  clk        in   1   system clock; single clock domain
//  reset_n    in   1   synchronous, active-low reset
//  address    in   2   0=DATA 1=STATUS 2=CTRL 3=reserved (reads 0)
//  chipselect in   1   slave select
//  write_n    in   1   active-low write strobe
//  writedata  in   32  write data
//  readdata   out  32  registered read data; valid the cycle after address is presented
//  usb_sck    out  1   SPI clock, mode 0 (idle low)
//  usb_sdi    out  1   MOSI toward the chip
//  usb_sdo    in   1   MISO from the chip
//  usb_scs_n  out  1   chip select, active low
//  usb_int_n  in   1   chip interrupt, active low, asynchronous
//  irq        out  1   interrupt to CPU
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clk) values:
//   - readdata=0, usb_sck=0, usb_sdi=0, usb_scs_n=1, irq=0
//   - div=DIV_RESET, busy=0, rx_valid=0, ovr=0, cs_assert=0, int_en=0
//   - FSM=IDLE
//   - Reset mid-transfer aborts immediately; no partial rx_data is kept.
//  Registers:
//   - DATA  wr [7:0]=tx byte; rd [7:0]=rx_data. A read clears rx_valid.
//   - STATUS rd [0]=busy [1]=rx_valid [2]=ovr [3]=int; write any value clears ovr.
//   - CTRL  rw [7:0]=div [8]=cs_assert [9]=int_en.
//   - usb_scs_n = ~cs_assert; software holds CS across multi-byte commands.
//  readdata is updated every clk from the mux of address. Bits not defined above read 0.
//  Write to DATA while busy=1: ignored; ovr<=1.
//  div is latched at transfer start; a CTRL write during a transfer affects only the next transfer.
//  FSM IDLE->LOAD->HIGH<->LOW->DONE->IDLE; half-period counter hc counts 0..div_l:
//   - IDLE: on DATA write -> shift<=tx, bitcnt<=0, busy<=1, usb_sdi<=tx[7]; ->LOAD
//   - LOAD: hold sck=0 for one half-period -> HIGH
//   - HIGH: sck=1; sample usb_sdo into shift LSB on entry; after half-period:
//     bitcnt==DATA_W-1 -> DONE, else -> LOW
//   - LOW: sck=0; drive next MSB on usb_sdi on entry; bitcnt++; after half-period -> HIGH
//   - DONE: sck=0, rx_data<=shift, rx_valid<=1, busy<=0 (one cycle) -> IDLE
//  Latency: from write cycle to busy=0 = 2 + 2*DATA_W*(div+1) clk cycles.
//  With div=0: 18 cycles.
//  DATA read in the same cycle DONE sets rx_valid: set wins; rx_valid stays 1.
//  usb_int_n passes through a 2-FF synchronizer; int = ~sync.
//  irq = int_en & int; level, no latch.
//  usb_sdo is sampled unsynchronized. The chip guarantees setup relative to the SCK rising edge we generate.
// STRUCTURE
//  Shared package usb_spi_pkg:
//   - state enum: IDLE, LOAD, HIGH, LOW, DONE
//   - register address constants: ADDR_DATA/STATUS/CTRL
//   - STATUS/CTRL bit indices
//   - DIV_W=8
//  One sub-module usb_spi_shifter: tx/rx shift register + bit counter, controlled by FSM strobes.
//  Avalon register file and FSM stay in the top.
// TESTING
//  1. Reset, then read each address -> STATUS=0, CTRL=0x004, DATA=0; usb_scs_n=1, usb_sck=0.
//  2. CTRL=0x100, div=0, write DATA=0xA5 with SDO model returning 0x3C:
//     - usb_sdi shows 1,0,1,0,0,1,0,1 on the 8 SCK rising edges
//     - busy clears 18 cycles after the write
//     - DATA reads 0x3C; rx_valid=1 before the read, 0 after
//  3. div=3: SCK high and low phases are each 4 clk cycles; 8 SCK pulses total.
//  4. Write DATA=0x11 then DATA=0x22 while busy:
//     - only 0x11 is shifted out; STATUS.ovr=1
//     - writing STATUS clears ovr
//  5. Assert reset_n=0 mid-transfer at bit 3:
//     - next clk: sck=0, scs_n=1, busy=0, rx_valid=0
//     - a new transfer after reset works normally
//  6. int_en=1, drive usb_int_n low -> irq=1 exactly 2 clks later; release -> irq=0 after 2 clks.

Source files
------------

// File: rtl/usb_spi_pkg.sv
// rtl/usb_spi_pkg.sv - shared types and register map for the USB host SPI master
package usb_spi_pkg;

    localparam int DIV_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HIGH,
        LOW,
        DONE
    } state_t;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_RXV  = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_INT  = 3;

    localparam int CTRL_CS    = 8;
    localparam int CTRL_INTEN = 9;

endpackage

// File: rtl/usb_spi_shifter.sv
// rtl/usb_spi_shifter.sv - full-duplex MSB-first shift register and bit counter
module usb_spi_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              sample,
    input  logic              advance,
    input  logic [DATA_W-1:0] tx,
    input  logic              sdo,
    output logic [DATA_W-1:0] shift,
    output logic              last,
    output logic              sdi
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0] bitcnt;

    // sdi is held separately so the rising-edge sample never disturbs the outgoing bit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift  <= '0;
            bitcnt <= '0;
            sdi    <= 1'b0;
        end else if (load) begin
            shift  <= tx;
            bitcnt <= '0;
            sdi    <= tx[DATA_W-1];
        end else begin
            if (sample) begin
                shift <= {shift[DATA_W-2:0], sdo};
            end
            if (advance) begin
                sdi    <= shift[DATA_W-1];
                bitcnt <= bitcnt + 1'b1;
            end
        end
    end

    assign last = (bitcnt == LAST_BIT);

endmodule

// File: rtl/usb_spi_master.sv
// rtl/usb_spi_master.sv - Avalon-MM register file and SPI mode-0 sequencer for the USB host chip
module usb_spi_master
    import usb_spi_pkg::*;
#(
    parameter logic [DIV_W-1:0] DIV_RESET = 8'd4,
    parameter int               DATA_W    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        usb_sck,
    output logic        usb_sdi,
    input  logic        usb_sdo,
    output logic        usb_scs_n,
    input  logic        usb_int_n,
    output logic        irq
);

    state_t             state, next_state;
    logic [DIV_W-1:0]   hc, div, div_l;
    logic               cs_assert, int_en, rx_valid, ovr;
    logic [DATA_W-1:0]  rx_data, shift;
    logic [1:0]         int_sync;
    logic               busy, sample, advance, last, int_act;
    logic               wr, rd, wr_data, start, phase_end;
    logic [31:0]        rd_mux;
    logic               unused_wdata;

    assign wr        = chipselect & ~write_n;
    assign rd        = chipselect & write_n;
    assign wr_data   = wr && (address == ADDR_DATA);
    assign start     = wr_data && (state == IDLE);
    assign phase_end = (hc == div_l);
    assign int_act   = ~int_sync[1];
    assign unused_wdata = ^writedata[31:CTRL_INTEN+1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            hc    <= '0;
        end else begin
            state <= next_state;
            hc    <= (state == IDLE || next_state != state) ? '0 : hc + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start)     next_state = LOAD;
            LOAD: if (phase_end) next_state = HIGH;
            HIGH: if (phase_end) next_state = last ? DONE : LOW;
            LOW:  if (phase_end) next_state = HIGH;
            DONE:                next_state = IDLE;
            default:             next_state = IDLE;
        endcase
    end

    // shifter strobes fire on the edge that enters HIGH/LOW
    always_comb begin
        usb_sck = (state == HIGH);
        busy    = (state != IDLE);
        sample  = (next_state == HIGH) && (state != HIGH);
        advance = (next_state == LOW) && (state != LOW);
    end

    usb_spi_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start),
        .sample  (sample),
        .advance (advance),
        .tx      (writedata[DATA_W-1:0]),
        .sdo     (usb_sdo),
        .shift   (shift),
        .last    (last),
        .sdi     (usb_sdi)
    );

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:   rd_mux = 32'(rx_data);
            ADDR_STATUS: rd_mux = {28'b0, int_act, ovr, rx_valid, busy};
            ADDR_CTRL:   rd_mux = {22'b0, int_en, cs_assert, div};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div       <= DIV_RESET;
            div_l     <= DIV_RESET;
            cs_assert <= 1'b0;
            int_en    <= 1'b0;
            ovr       <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            int_sync  <= 2'b11;
            readdata  <= '0;
        end else begin
            int_sync <= {int_sync[0], usb_int_n};
            readdata <= rd_mux;
            if (start) begin
                div_l <= div;
            end
            if (wr && address == ADDR_CTRL) begin
                div       <= writedata[DIV_W-1:0];
                cs_assert <= writedata[CTRL_CS];
                int_en    <= writedata[CTRL_INTEN];
            end
            if (wr && address == ADDR_STATUS) begin
                ovr <= 1'b0;
            end else if (wr_data && busy) begin
                ovr <= 1'b1;
            end
            // completion beats a coincident DATA read
            if (state == DONE) begin
                rx_valid <= 1'b1;
                rx_data  <= shift;
            end else if (rd && address == ADDR_DATA) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign usb_scs_n = ~cs_assert;
    assign irq       = int_en & int_act;

endmodule
